truth_table_sweeper: RTL

Sequential stimulus-and-check stage for the 3-input minterm function blocks. It drives an input vector into a combinational function under test and walks it through every minterm from 0 to 2^N-1. At each step it captures the function's output and assembles the measured truth table, then compares that table bit-for-bit against an expected minterm mask. It replaces the hand-written `#1` stimulus sequences with a clocked, self-checking sweep that a bench or a higher-level controller can start and poll.

---
 rtl/truth_table_sweeper.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/truth_table_sweeper.sv
// Clocked truth-table sweeper: steps a minterm index through a combinational
// function, captures its output per minterm, and scores the table against a mask.
module truth_table_sweeper #(
    parameter  int N      = 3,
    parameter  int SETTLE = 1,
    localparam int T      = 1 << N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [T-1:0] expect_i,
    input  logic         r_i,
    output logic [N-1:0] vec_o,
    output logic         busy_o,
    output logic         done_o,
    output logic [T-1:0] table_o,
    output logic         pass_o,
    output logic [N-1:0] fail_idx_o,
    output logic [N:0]   mismatch_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_SAMPLE,
        S_DONE
    } state_e;

    localparam logic [3:0]   SETTLE_LOAD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
    localparam state_e       FIRST_STATE = (SETTLE > 0) ? S_APPLY : S_SAMPLE;
    localparam logic [N-1:0] VEC_LAST    = {N{1'b1}};
    localparam logic [N-1:0] VEC_ONE     = N'(1);
    localparam logic [N:0]   CNT_ONE     = (N + 1)'(1);

    state_e       state_q, state_d;
    logic [3:0]   settle_q, settle_d;
    logic [N-1:0] vec_q, vec_d;
    logic         busy_q, busy_d;
    logic [T-1:0] table_q, table_d;
    logic         pass_q, pass_d;
    logic [N-1:0] fail_idx_q, fail_idx_d;
    logic [N:0]   mismatch_cnt_q, mismatch_cnt_d;
    logic [T-1:0] expect_q, expect_d;

    logic accept;
    logic mismatch;

    assign mismatch = (r_i != expect_q[vec_q]);

    // NOTE: every variable driven here gets a default before the case statement,
    // so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        settle_d       = settle_q;
        vec_d          = vec_q;
        busy_d         = busy_q;
        table_d        = table_q;
        pass_d         = pass_q;
        fail_idx_d     = fail_idx_q;
        mismatch_cnt_d = mismatch_cnt_q;
        expect_d       = expect_q;
        accept         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                accept = start_i;
            end
            S_APPLY: begin
                if (settle_q == 4'd0) begin
                    state_d = S_SAMPLE;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            S_SAMPLE: begin
                table_d[vec_q] = r_i;
                if (mismatch) begin
                    mismatch_cnt_d = mismatch_cnt_q + CNT_ONE;
                    if (mismatch_cnt_q == '0) begin
                        fail_idx_d = vec_q;
                    end
                end
                if (vec_q == VEC_LAST) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    pass_d  = (mismatch_cnt_q == '0) && !mismatch;
                end else begin
                    vec_d    = vec_q + VEC_ONE;
                    settle_d = SETTLE_LOAD;
                    state_d  = FIRST_STATE;
                end
            end
            S_DONE: begin
                // The edge that drops done also returns to idle, so a start seen
                // there is the earliest legal restart and is taken.
                state_d = S_IDLE;
                accept  = start_i;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            expect_d       = expect_i;
            vec_d          = '0;
            table_d        = '0;
            pass_d         = 1'b0;
            fail_idx_d     = '0;
            mismatch_cnt_d = '0;
            busy_d         = 1'b1;
            settle_d       = SETTLE_LOAD;
            state_d        = FIRST_STATE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            settle_q       <= '0;
            vec_q          <= '0;
            busy_q         <= 1'b0;
            table_q        <= '0;
            pass_q         <= 1'b0;
            fail_idx_q     <= '0;
            mismatch_cnt_q <= '0;
            expect_q       <= '0;
        end else begin
            state_q        <= state_d;
            settle_q       <= settle_d;
            vec_q          <= vec_d;
            busy_q         <= busy_d;
            table_q        <= table_d;
            pass_q         <= pass_d;
            fail_idx_q     <= fail_idx_d;
            mismatch_cnt_q <= mismatch_cnt_d;
            expect_q       <= expect_d;
        end
    end

    assign vec_o          = vec_q;
    assign busy_o         = busy_q;
    assign done_o         = (state_q == S_DONE);
    assign table_o        = table_q;
    assign pass_o         = pass_q;
    assign fail_idx_o     = fail_idx_q;
    assign mismatch_cnt_o = mismatch_cnt_q;

endmodule
